jno_check_gen: RTL and testbench

JNO_CHECK_GEN -- requirements
Module: jno_check_gen

---
 rtl/jno_check_gen_if.sv | 28 ++
 rtl/jno_check_gen.sv | 92 +++++++++
 tb/tb_jno_check_gen.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/jno_check_gen_if.sv
// Handshake and status bundle between the decoder/ALU/PC side and jno_check_gen.
// The slave modport is the checker's view of the bundle.
interface jno_check_gen_if #(
  parameter int AW = 8,
  parameter int CW = 8
);
  logic          alu_valid;
  logic          alu_ovf;
  logic          jno_req;
  logic [AW-1:0] jno_target;
  logic          jno_ready;
  logic          branch_valid;
  logic [AW-1:0] branch_target;
  logic          pc_ack;
  logic [1:0]    check;
  logic [CW-1:0] ovf_count;
  logic          timeout_err;

  modport master (
    output alu_valid, alu_ovf, jno_req, jno_target, pc_ack,
    input  jno_ready, branch_valid, branch_target, check, ovf_count, timeout_err
  );

  modport slave (
    input  alu_valid, alu_ovf, jno_req, jno_target, pc_ack,
    output jno_ready, branch_valid, branch_target, check, ovf_count, timeout_err
  );
endinterface

// File: rtl/jno_check_gen.sv
// Jump-if-no-overflow evaluator: tracks the ALU overflow flag, decides JNO
// branches and issues them to the PC with an ack/timeout handshake.
module jno_check_gen #(
  parameter int AW      = 8,
  parameter int TIMEOUT = 15,
  parameter int CW      = 8
) (
  input  logic            clk,
  input  logic            reset_n,
  jno_check_gen_if.slave  bus
);

  localparam int            WW        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, EVAL, ISSUE} state_t;

  state_t        state;
  logic          ovf_flag;
  logic [CW-1:0] ovf_cnt;
  logic [AW-1:0] tgt;
  logic [WW-1:0] wait_cnt;
  logic          bv;
  logic          err;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + CW'(1);
  endfunction

  // Overflow tracking runs regardless of what the branch FSM is doing.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_flag <= 1'b0;
      ovf_cnt  <= '0;
    end else if (bus.alu_valid) begin
      ovf_flag <= bus.alu_ovf;
      if (bus.alu_ovf) ovf_cnt <= sat_inc(ovf_cnt);
    end
  end

  // EVAL reads the registered flag, so an ALU result in the EVAL cycle itself
  // only affects the next JNO, not this one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      tgt      <= '0;
      wait_cnt <= '0;
      bv       <= 1'b0;
      err      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.jno_req) begin
            tgt   <= bus.jno_target;
            state <= EVAL;
          end
        end
        EVAL: begin
          if (ovf_flag) begin
            state <= IDLE;
          end else begin
            state    <= ISSUE;
            bv       <= 1'b1;
            wait_cnt <= '0;
          end
        end
        ISSUE: begin
          // An ack on the final wait cycle still counts as delivered.
          if (bus.pc_ack) begin
            state <= IDLE;
            bv    <= 1'b0;
          end else if (wait_cnt == WAIT_LAST) begin
            state <= IDLE;
            bv    <= 1'b0;
            err   <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.jno_ready     = (state == IDLE);
  assign bus.branch_valid  = bv;
  assign bus.branch_target = tgt;
  assign bus.check         = {bv, ovf_flag};
  assign bus.ovf_count     = ovf_cnt;
  assign bus.timeout_err   = err;

endmodule

// File: tb/tb_jno_check_gen.sv
// Directed bench for jno_check_gen: cycle-by-cycle comparison against a
// phase-count model, plus literal expectations at the key cycles.
module tb_jno_check_gen;

  localparam int AW      = 8;
  localparam int CW      = 8;
  localparam int TIMEOUT = 15;

  logic clk;
  logic reset_n;
  int   checks   = 0;
  int   failures = 0;
  bit   cmp_en   = 0;

  jno_check_gen_if #(.AW(AW), .CW(CW)) bus ();

  jno_check_gen #(.AW(AW), .TIMEOUT(TIMEOUT), .CW(CW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: phase 0 = free, 1 = deciding, k>=2 = k-1'th cycle of a pending branch.
  int         m_phase;
  logic       m_flag;
  int         m_cnt;
  logic [7:0] m_tgt;
  logic       m_err;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_phase = 0; m_flag = 0; m_cnt = 0; m_tgt = 8'h00; m_err = 0;
    end else begin
      logic seen_flag;
      seen_flag = m_flag;
      if (bus.alu_valid) begin
        m_flag = bus.alu_ovf;
        if (bus.alu_ovf && m_cnt < 255) m_cnt = m_cnt + 1;
      end
      if (m_phase == 0) begin
        if (bus.jno_req) begin
          m_phase = 1;
          m_tgt   = bus.jno_target;
        end
      end else if (m_phase == 1) begin
        m_phase = seen_flag ? 0 : 2;
      end else if (bus.pc_ack) begin
        m_phase = 0;
      end else if (m_phase - 1 >= TIMEOUT) begin
        m_phase = 0;
        m_err   = 1;
      end else begin
        m_phase = m_phase + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en && reset_n) begin
      chk("model_ready",  32'(bus.jno_ready),     32'(m_phase == 0));
      chk("model_bvalid", 32'(bus.branch_valid),  32'(m_phase >= 2));
      chk("model_target", 32'(bus.branch_target), 32'(m_tgt));
      chk("model_check",  32'(bus.check),         32'({(m_phase >= 2), m_flag}));
      chk("model_count",  32'(bus.ovf_count),     32'(m_cnt));
      chk("model_err",    32'(bus.timeout_err),   32'(m_err));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected finish before 100000");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    reset_n        = 1'b0;
    bus.alu_valid  = 1'b0;
    bus.alu_ovf    = 1'b0;
    bus.jno_req    = 1'b0;
    bus.jno_target = 8'h00;
    bus.pc_ack     = 1'b0;
    repeat (2) step();
    chk("rst_ready",  32'(bus.jno_ready),     32'd1);
    chk("rst_bvalid", 32'(bus.branch_valid),  32'd0);
    chk("rst_target", 32'(bus.branch_target), 32'd0);
    chk("rst_check",  32'(bus.check),         32'd0);
    chk("rst_count",  32'(bus.ovf_count),     32'd0);
    chk("rst_err",    32'(bus.timeout_err),   32'd0);
    reset_n = 1'b1;
    cmp_en  = 1;
    step();

    // Taken branch, ack in the T+4 cycle.
    bus.jno_req = 1'b1; bus.jno_target = 8'h3C;
    step();
    bus.jno_req = 1'b0;
    chk("taken_eval_ready", 32'(bus.jno_ready), 32'd0);
    step();
    chk("taken_bvalid", 32'(bus.branch_valid),  32'd1);
    chk("taken_target", 32'(bus.branch_target), 32'h3C);
    chk("taken_check",  32'(bus.check),         32'b10);
    step();
    step();
    bus.pc_ack = 1'b1;
    step();
    bus.pc_ack = 1'b0;
    chk("taken_ack_ready",  32'(bus.jno_ready),    32'd1);
    chk("taken_ack_bvalid", 32'(bus.branch_valid), 32'd0);

    // Not taken: overflow seen before the request.
    bus.alu_valid = 1'b1; bus.alu_ovf = 1'b1;
    step();
    bus.alu_valid = 1'b0; bus.alu_ovf = 1'b0;
    bus.jno_req = 1'b1; bus.jno_target = 8'h55;
    step();
    bus.jno_req = 1'b0;
    chk("nt_check", 32'(bus.check), 32'b01);
    step();
    chk("nt_ready",  32'(bus.jno_ready),    32'd1);
    chk("nt_bvalid", 32'(bus.branch_valid), 32'd0);
    chk("nt_count",  32'(bus.ovf_count),    32'd1);

    // Overflow in the accept cycle counts; overflow in EVAL does not.
    bus.alu_valid = 1'b1; bus.alu_ovf = 1'b0;
    step();
    bus.alu_ovf = 1'b1;
    bus.jno_req = 1'b1; bus.jno_target = 8'h11;
    step();
    bus.jno_req = 1'b0; bus.alu_valid = 1'b0; bus.alu_ovf = 1'b0;
    step();
    chk("acc_ovf_ready",  32'(bus.jno_ready),    32'd1);
    chk("acc_ovf_bvalid", 32'(bus.branch_valid), 32'd0);
    bus.alu_valid = 1'b1;
    step();
    bus.alu_valid = 1'b0;
    bus.jno_req = 1'b1; bus.jno_target = 8'h22;
    step();
    bus.jno_req = 1'b0;
    bus.alu_valid = 1'b1; bus.alu_ovf = 1'b1;
    step();
    bus.alu_valid = 1'b0; bus.alu_ovf = 1'b0;
    chk("eval_ovf_bvalid", 32'(bus.branch_valid),  32'd1);
    chk("eval_ovf_target", 32'(bus.branch_target), 32'h22);
    chk("eval_ovf_check",  32'(bus.check),         32'b11);
    chk("eval_ovf_count",  32'(bus.ovf_count),     32'd3);
    bus.pc_ack = 1'b1;
    step();
    bus.pc_ack = 1'b0;
    chk("eval_ovf_ready", 32'(bus.jno_ready), 32'd1);

    // Timeout with no ack: 15 ISSUE cycles, then sticky error.
    bus.alu_valid = 1'b1; bus.alu_ovf = 1'b0;
    step();
    bus.alu_valid = 1'b0;
    bus.jno_req = 1'b1; bus.jno_target = 8'h77;
    step();
    bus.jno_req = 1'b0;
    step();
    repeat (14) step();
    chk("to_last_bvalid", 32'(bus.branch_valid), 32'd1);
    chk("to_last_err",    32'(bus.timeout_err),  32'd0);
    step();
    chk("to_bvalid", 32'(bus.branch_valid), 32'd0);
    chk("to_ready",  32'(bus.jno_ready),    32'd1);
    chk("to_err",    32'(bus.timeout_err),  32'd1);
    repeat (3) step();
    chk("to_sticky", 32'(bus.timeout_err), 32'd1);

    // Ack in the 15th ISSUE cycle beats the timeout.
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    chk("rst2_err", 32'(bus.timeout_err), 32'd0);
    bus.jno_req = 1'b1; bus.jno_target = 8'h5A;
    step();
    bus.jno_req = 1'b0;
    step();
    repeat (14) step();
    bus.pc_ack = 1'b1;
    step();
    bus.pc_ack = 1'b0;
    chk("ack15_ready",  32'(bus.jno_ready),    32'd1);
    chk("ack15_bvalid", 32'(bus.branch_valid), 32'd0);
    chk("ack15_err",    32'(bus.timeout_err),  32'd0);

    // Saturation of the overflow counter.
    bus.alu_valid = 1'b1; bus.alu_ovf = 1'b1;
    repeat (300) step();
    bus.alu_valid = 1'b0; bus.alu_ovf = 1'b0;
    chk("sat_count", 32'(bus.ovf_count), 32'd255);
    step();
    chk("sat_hold", 32'(bus.ovf_count), 32'd255);

    // Asynchronous reset between edges while a branch is issuing.
    bus.alu_valid = 1'b1; bus.alu_ovf = 1'b0;
    step();
    bus.alu_valid = 1'b0;
    bus.jno_req = 1'b1; bus.jno_target = 8'h66;
    step();
    bus.jno_req = 1'b0;
    step();
    chk("ar_pre_bvalid", 32'(bus.branch_valid), 32'd1);
    #2;
    reset_n = 1'b0;
    bus.jno_req = 1'b1; bus.jno_target = 8'hA5;
    #1;
    chk("ar_ready",  32'(bus.jno_ready),     32'd1);
    chk("ar_bvalid", 32'(bus.branch_valid),  32'd0);
    chk("ar_target", 32'(bus.branch_target), 32'd0);
    chk("ar_check",  32'(bus.check),         32'd0);
    chk("ar_count",  32'(bus.ovf_count),     32'd0);
    chk("ar_err",    32'(bus.timeout_err),   32'd0);
    #1;
    reset_n = 1'b1;
    step();
    bus.jno_req = 1'b0;
    chk("ar_accept_ready",  32'(bus.jno_ready),     32'd0);
    chk("ar_accept_target", 32'(bus.branch_target), 32'hA5);
    step();
    chk("ar_issue_bvalid", 32'(bus.branch_valid), 32'd1);
    bus.pc_ack = 1'b1;
    step();
    bus.pc_ack = 1'b0;
    chk("ar_done_ready", 32'(bus.jno_ready),   32'd1);
    chk("ar_done_err",   32'(bus.timeout_err), 32'd0);
    repeat (2) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
